fft_r2sdf_stage: RTL and testbench
==================================

Name: fft_r2sdf_stage

Overview:
- One parametrised radix-2 single-path delay-feedback (R2SDF) decimation-in-frequency stage.
- A chain of LOG2N stages, with LOG2D = LOG2N-1 down to 0, forms a streaming N-point FFT/IFFT.
- This generalises the fixed 16-point core to any power-of-two length.
- Adds runtime scaling, a valid flag and output saturation; the same ED/START/RDY streaming protocol is kept.

Parameters:
- DW, 32: input sample width per real/imag component, signed.
- TW, 16: twiddle width, signed Q1.(TW-2), so 1.0 = 2^(TW-2).
- LOG2D, 3: log2 of the delay-line depth. D = 2^LOG2D; the stage processes blocks of 2D samples.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- ED  in  1  clock enable; every ED=1 cycle is one input/output sample slot.
- START  in  1  frame restart.
- IFFT  in  1  1 = conjugate twiddles; latched at START.
- SCALE  in  1  1 = arithmetic shift right by 1 on outputs; latched at START.
- DIReal, DIImag  in  DW each  input sample.
- TW_ADDR  out  LOG2D  twiddle ROM address (external ROM, ED-enabled, 1-cycle registered read).
- TW_RE, TW_IM  in  TW each  ROM data: round(cos(pi*n/D)*2^(TW-2)) and round(-sin(pi*n/D)*2^(TW-2)).
- DOReal, DOImag  out  DW+1 each  registered output sample.
- VLD  out  1  DO carries a valid sample.
- RDY  out  1  one-slot pulse coincident with y[0] of each block.

Behaviour:
- Reset (RST): ct=0, DO=0, VLD=0, RDY=0, TW_ADDR=0, latched IFFT=0, latched SCALE=0. Delay-line contents are don't-care and are masked by VLD.
- Priority: RST > START > ED.
- START cycle:
  - Sets ct=0 and clears VLD, RDY and the valid pipeline.
  - Latches IFFT and SCALE.
  - Accepts no sample; x[0] is the first ED cycle after START.
- ED=0: all registers, including the delay line and ct, hold. DO, VLD, RDY and TW_ADDR are held.
- Counter ct (LOG2D+1 bits) advances on each ED slot and wraps at 2D. Blocks then follow back-to-back with no gap.
- Phase A (ct < D):
  - The delay line takes x[ct].
  - The delay-line output (the difference from the previous block) goes to the twiddle multiplier with n = ct.
- Phase B (ct >= D):
  - a = delay-line output x[n], b = input x[n+D].
  - The sum a+b (DW+1 bits, exact) goes to the output path.
  - The difference a-b goes into the delay line.
- Output order per block: y[n] = x[n]+x[n+D] for n = 0..D-1, then y[D+n] = (x[n]-x[n+D])*W^n.
  - W^n = exp(-j*pi*n/D) for FFT; its conjugate for IFFT (TW_IM negated).
- Complex multiply:
  - re = d_r*TW_RE - d_i*TWi; im = d_r*TWi + d_i*TW_RE, with TWi = ±TW_IM.
  - Full-precision products are summed, then rounded half-up: add 2^(TW-3), arithmetic shift right TW-2.
  - The result saturates to the signed DW+1 range [-2^DW, 2^DW-1].
- The sum path is delay-matched to the multiplier path.
- Latency: y[0] is on DO exactly D+4 ED slots after x[0] is accepted. y[k] follows in consecutive slots.
- SCALE=1: each output component is arithmetic-shifted right by 1 (floor) after saturation, and sign-extended to DW+1.
- VLD rises with the first y[0] after RST/START and stays high while ED slots continue. RDY=1 only in the slot carrying y[0] of each block.
- TW_ADDR is driven so that the ROM data matching index n is present in the slot the multiplier consumes n. Phase-B slots: don't-care.
- Mid-operation RST or START: the current block is aborted. VLD falls the next cycle; the new y[0] arrives D+4 slots after the new x[0].
- Twiddle n=0 with TW_RE = 2^(TW-2) must pass data unchanged (no rounding bias).

Test Plan:
- Impulse (DW=16, TW=16, LOG2D=3, ED=1): x[0]=1000, others 0 -> y[0]=1000 and y[8]=1000, all others 0. RDY and first VLD occur 12 slots after x[0].
- Constant input x=100+0j for 2 blocks:
  - SCALE=0 -> y[0..7]=200, y[8..15]=0 in both blocks. RDY pulses 16 slots apart.
  - SCALE=1 -> y[0..7]=100.
  - x=-1 with SCALE=1 -> y[0..7]=-1 (floor).
- Twiddle rounding: x[1]=4096, others 0.
  - FFT -> y[1]=4096, y[9]=3784-1567j.
  - IFFT -> y[9]=3784+1568j.
- Saturation: x[3]=32767+32767j, x[11]=-32768-32768j -> y[3]=-1-1j, y[11]=65535-35467j (real saturated).
- ED stall: ED=0 for 5 cycles mid-block with random data -> DO sequence identical to the unstalled run; DO, VLD, RDY held during the stall.
- Abort:
  - START at slot 5 of a block -> VLD=0 next cycle, y[0] of the new block 12 slots after the new x[0].
  - RST mid-block -> DO=0, VLD=0, RDY=0 next cycle.

Source files
------------

// File: rtl/fft_r2sdf_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fft_r2sdf_stage : parametrised radix-2 SDF decimation-in-frequency stage  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module fft_r2sdf_stage #(
  parameter int DW    = 32,
  parameter int TW    = 16,
  parameter int LOG2D = 3
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ED,
  input  logic                    START,
  input  logic                    IFFT,
  input  logic                    SCALE,
  input  logic signed [DW-1:0]    DIReal,
  input  logic signed [DW-1:0]    DIImag,
  output logic        [LOG2D-1:0] TW_ADDR,
  input  logic signed [TW-1:0]    TW_RE,
  input  logic signed [TW-1:0]    TW_IM,
  output logic signed [DW:0]      DOReal,
  output logic signed [DW:0]      DOImag,
  output logic                    VLD,
  output logic                    RDY
);
  localparam int D  = 1 << LOG2D;
  localparam int PW = DW + TW + 3;
  localparam logic signed [TW:0]   TW_ONE = (TW+1)'(1) << (TW-2);
  localparam logic signed [PW-1:0] HALF   = PW'(1) << (TW-3);
  localparam logic [LOG2D:0]       CT_D   = (LOG2D+1)'(D);

  logic [LOG2D:0]       ct_q, ct_d;
  logic                 ifft_q, ifft_d, scale_q, scale_d;
  logic signed [DW:0]   dl_re_q [D];
  logic signed [DW:0]   dl_re_d [D];
  logic signed [DW:0]   dl_im_q [D];
  logic signed [DW:0]   dl_im_d [D];
  logic signed [DW:0]   s1_re_q, s1_re_d, s1_im_q, s1_im_d;
  logic                 s1_mul_q, s1_mul_d;
  logic signed [PW-1:0] s2_re_q, s2_re_d, s2_im_q, s2_im_d;
  logic signed [DW:0]   s3_re_q, s3_re_d, s3_im_q, s3_im_d;
  logic signed [DW:0]   do_re_q, do_re_d, do_im_q, do_im_d;
  logic [3:0]           vld_pipe_q, vld_pipe_d, rdy_pipe_q, rdy_pipe_d;

  logic                 phase_b, at_mid;
  logic signed [DW:0]   x_re, x_im, head_re, head_im;
  logic signed [DW:0]   sum_re, sum_im, dif_re, dif_im;
  logic signed [TW:0]   w_re, w_im;
  logic signed [PW-1:0] a_re, a_im, b_re, b_im, p_re, p_im, r_re, r_im;

  assign phase_b = ct_q[LOG2D];
  assign at_mid  = (ct_q == CT_D);
  assign x_re    = {DIReal[DW-1], DIReal};
  assign x_im    = {DIImag[DW-1], DIImag};
  assign head_re = dl_re_q[D-1];
  assign head_im = dl_im_q[D-1];
  assign sum_re  = head_re + x_re;
  assign sum_im  = head_im + x_im;
  assign dif_re  = head_re - x_re;
  assign dif_im  = head_im - x_im;

  // Sums ride the multiplier with a unit twiddle so both paths share latency.
  assign w_re = s1_mul_q ? (TW+1)'(TW_RE) : TW_ONE;
  assign w_im = !s1_mul_q ? '0 : (ifft_q ? -(TW+1)'(TW_IM) : (TW+1)'(TW_IM));
  assign a_re = PW'(s1_re_q);
  assign a_im = PW'(s1_im_q);
  assign b_re = PW'(w_re);
  assign b_im = PW'(w_im);
  assign p_re = a_re * b_re - a_im * b_im;
  assign p_im = a_re * b_im + a_im * b_re;
  assign r_re = (s2_re_q + HALF) >>> (TW-2);
  assign r_im = (s2_im_q + HALF) >>> (TW-2);

  function automatic logic signed [DW:0] sat(input logic signed [PW-1:0] v);
    if (v[PW-1:DW] == {(PW-DW){v[PW-1]}}) return v[DW:0];
    return v[PW-1] ? {1'b1, {DW{1'b0}}} : {1'b0, {DW{1'b1}}};
  endfunction

  always_comb begin
    ct_d       = ct_q;
    ifft_d     = ifft_q;
    scale_d    = scale_q;
    dl_re_d    = dl_re_q;
    dl_im_d    = dl_im_q;
    s1_re_d    = s1_re_q;
    s1_im_d    = s1_im_q;
    s1_mul_d   = s1_mul_q;
    s2_re_d    = s2_re_q;
    s2_im_d    = s2_im_q;
    s3_re_d    = s3_re_q;
    s3_im_d    = s3_im_q;
    do_re_d    = do_re_q;
    do_im_d    = do_im_q;
    vld_pipe_d = vld_pipe_q;
    rdy_pipe_d = rdy_pipe_q;
    if (START) begin
      ct_d       = '0;
      ifft_d     = IFFT;
      scale_d    = SCALE;
      vld_pipe_d = '0;
      rdy_pipe_d = '0;
    end else if (ED) begin
      ct_d       = ct_q + (LOG2D+1)'(1);
      dl_re_d[0] = phase_b ? dif_re : x_re;
      dl_im_d[0] = phase_b ? dif_im : x_im;
      for (int i = 1; i < D; i++) begin
        dl_re_d[i] = dl_re_q[i-1];
        dl_im_d[i] = dl_im_q[i-1];
      end
      s1_re_d    = phase_b ? sum_re : head_re;
      s1_im_d    = phase_b ? sum_im : head_im;
      s1_mul_d   = !phase_b;
      s2_re_d    = p_re;
      s2_im_d    = p_im;
      s3_re_d    = sat(r_re);
      s3_im_d    = sat(r_im);
      do_re_d    = scale_q ? (s3_re_q >>> 1) : s3_re_q;
      do_im_d    = scale_q ? (s3_im_q >>> 1) : s3_im_q;
      // Once the first sum has entered, every later slot carries real data.
      vld_pipe_d = {vld_pipe_q[2:0], vld_pipe_q[0] | at_mid};
      rdy_pipe_d = {rdy_pipe_q[2:0], at_mid};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ct_q       <= '0;
      ifft_q     <= 1'b0;
      scale_q    <= 1'b0;
      s1_re_q    <= '0;
      s1_im_q    <= '0;
      s1_mul_q   <= 1'b0;
      s2_re_q    <= '0;
      s2_im_q    <= '0;
      s3_re_q    <= '0;
      s3_im_q    <= '0;
      do_re_q    <= '0;
      do_im_q    <= '0;
      vld_pipe_q <= '0;
      rdy_pipe_q <= '0;
    end else begin
      ct_q       <= ct_d;
      ifft_q     <= ifft_d;
      scale_q    <= scale_d;
      s1_re_q    <= s1_re_d;
      s1_im_q    <= s1_im_d;
      s1_mul_q   <= s1_mul_d;
      s2_re_q    <= s2_re_d;
      s2_im_q    <= s2_im_d;
      s3_re_q    <= s3_re_d;
      s3_im_q    <= s3_im_d;
      do_re_q    <= do_re_d;
      do_im_q    <= do_im_d;
      vld_pipe_q <= vld_pipe_d;
      rdy_pipe_q <= rdy_pipe_d;
    end
  end

  // Delay-line contents are masked by VLD, so they need no reset.
  always_ff @(posedge CLK) begin
    dl_re_q <= dl_re_d;
    dl_im_q <= dl_im_d;
  end

  assign TW_ADDR = ct_q[LOG2D-1:0];
  assign DOReal  = do_re_q;
  assign DOImag  = do_im_q;
  assign VLD     = vld_pipe_q[3];
  assign RDY     = rdy_pipe_q[3];

endmodule
`default_nettype wire

// File: tb/tb_fft_r2sdf_stage.sv
`default_nettype none
// Bench for fft_r2sdf_stage: random and directed frames against a block-level
// model of the stage equations, with the twiddle ROM modelled here.
module tb_fft_r2sdf_stage;
  localparam int DW    = 16;
  localparam int TW    = 16;
  localparam int LOG2D = 3;
  localparam int D     = 1 << LOG2D;
  localparam int N2    = 2 * D;
  localparam int LAT   = D + 4;
  localparam int MAXS  = 128;
  localparam longint SENT = -999999;

  logic CLK = 1'b0, RST = 1'b1, ED = 1'b0, START = 1'b0, IFFT = 1'b0, SCALE = 1'b0;
  logic signed [DW-1:0]  DIReal = '0, DIImag = '0;
  logic [LOG2D-1:0]      TW_ADDR;
  logic signed [TW-1:0]  TW_RE = '0, TW_IM = '0;
  logic signed [DW:0]    DOReal, DOImag;
  logic                  VLD, RDY;

  int     n_chk = 0, n_err = 0;
  int     rom_re [D];
  int     rom_im [D];
  longint xr [MAXS];
  longint xi [MAXS];
  longint er [MAXS];
  longint ei [MAXS];
  longint orr [MAXS];
  longint oi [MAXS];
  longint sr [MAXS];
  longint si [MAXS];

  fft_r2sdf_stage #(.DW(DW), .TW(TW), .LOG2D(LOG2D)) dut (
    .CLK(CLK), .RST(RST), .ED(ED), .START(START), .IFFT(IFFT), .SCALE(SCALE),
    .DIReal(DIReal), .DIImag(DIImag), .TW_ADDR(TW_ADDR), .TW_RE(TW_RE), .TW_IM(TW_IM),
    .DOReal(DOReal), .DOImag(DOImag), .VLD(VLD), .RDY(RDY)
  );

  always #5 CLK = ~CLK;

  // External twiddle ROM: ED-enabled, one-cycle registered read.
  always @(posedge CLK) begin
    if (ED) begin
      TW_RE <= TW'(rom_re[TW_ADDR]);
      TW_IM <= TW'(rom_im[TW_ADDR]);
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rnd_near(input real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
  endfunction

  function automatic longint round_tw(input longint p);
    real rp;
    rp = p;
    return longint'($rtoi($floor(rp / (2.0 ** (TW-2)) + 0.5)));
  endfunction

  function automatic longint post(input longint v, input bit scale);
    longint lim, s;
    lim = longint'(1) << DW;
    s = (v > lim - 1) ? lim - 1 : ((v < -lim) ? -lim : v);
    if (!scale) return s;
    return (s < 0 && (s % 2) != 0) ? s / 2 - 1 : s / 2;
  endfunction

  // Block-level reference: y[n]=x[n]+x[n+D], y[D+n]=(x[n]-x[n+D])*W^n.
  task automatic build_model(input int nblk, input bit ifft, input bit scale);
    for (int b = 0; b < nblk; b++) begin
      for (int n = 0; n < D; n++) begin
        longint ar, ai, br, bi, dr, di, wr, wi;
        ar = xr[b*N2+n];   ai = xi[b*N2+n];
        br = xr[b*N2+n+D]; bi = xi[b*N2+n+D];
        dr = ar - br;      di = ai - bi;
        wr = rom_re[n];
        wi = ifft ? -rom_im[n] : rom_im[n];
        er[b*N2+n]   = post(ar + br, scale);
        ei[b*N2+n]   = post(ai + bi, scale);
        er[b*N2+D+n] = post(round_tw(dr*wr - di*wi), scale);
        ei[b*N2+D+n] = post(round_tw(dr*wi + di*wr), scale);
      end
    end
  endtask

  task automatic check_slot(input int s, input int nblk, input bit record);
    int k;
    k = s - LAT;
    if (k < 0) begin
      check($sformatf("vld_pre s%0d", s), longint'(VLD), 0);
      check($sformatf("rdy_pre s%0d", s), longint'(RDY), 0);
    end else begin
      check($sformatf("vld s%0d", s), longint'(VLD), 1);
      check($sformatf("rdy s%0d", s), longint'(RDY), longint'((k % N2) == 0));
      if (k < nblk * N2) begin
        check($sformatf("do_re y%0d", k), longint'(DOReal), er[k]);
        check($sformatf("do_im y%0d", k), longint'(DOImag), ei[k]);
        if (record) begin
          orr[k] = DOReal;
          oi[k]  = DOImag;
        end
      end
    end
  endtask

  task automatic run_frame(input bit ifft, input bit scale, input int nslots, input int stall_at);
    int nblk;
    nblk = (nslots >= LAT) ? (nslots - LAT) / N2 : 0;
    build_model(nblk, ifft, scale);
    for (int i = 0; i < MAXS; i++) begin
      orr[i] = SENT;
      oi[i]  = SENT;
    end
    @(negedge CLK);
    START = 1'b1; ED = 1'b1; IFFT = ifft; SCALE = scale;
    DIReal = DW'($urandom); DIImag = DW'($urandom);
    for (int s = 0; s < nslots; s++) begin
      if (s == stall_at) begin
        for (int c = 0; c < 5; c++) begin
          @(negedge CLK);
          START = 1'b0; ED = 1'b0;
          DIReal = DW'($urandom); DIImag = DW'($urandom);
          check_slot(s, nblk, 1'b0);
        end
      end
      @(negedge CLK);
      START = 1'b0; ED = 1'b1; IFFT = !ifft; SCALE = !scale;
      DIReal = DW'(xr[s]); DIImag = DW'(xi[s]);
      check_slot(s, nblk, 1'b1);
    end
  endtask

  task automatic reset_check(input string tag);
    @(negedge CLK);
    RST = 1'b1; ED = 1'b1; START = 1'b0;
    @(negedge CLK);
    RST = 1'b0; ED = 1'b0;
    check({tag, "_do_re"}, longint'(DOReal), 0);
    check({tag, "_do_im"}, longint'(DOImag), 0);
    check({tag, "_vld"}, longint'(VLD), 0);
    check({tag, "_rdy"}, longint'(RDY), 0);
    check({tag, "_addr"}, longint'(TW_ADDR), 0);
  endtask

  task automatic fill_const(input longint re, input longint im);
    for (int i = 0; i < MAXS; i++) begin
      xr[i] = re;
      xi[i] = im;
    end
  endtask

  task automatic fill_rand();
    logic signed [DW-1:0] t;
    for (int i = 0; i < MAXS; i++) begin
      t = DW'($urandom); xr[i] = t;
      t = DW'($urandom); xi[i] = t;
    end
  endtask

  initial begin
    int nz;
    for (int n = 0; n < D; n++) begin
      rom_re[n] = rnd_near($cos(3.14159265358979 * n / D) * (2.0 ** (TW-2)));
      rom_im[n] = rnd_near(-$sin(3.14159265358979 * n / D) * (2.0 ** (TW-2)));
    end
    repeat (3) @(negedge CLK);
    reset_check("rst");

    // Impulse
    fill_const(0, 0); xr[0] = 1000;
    run_frame(1'b0, 1'b0, N2 + LAT, -1);
    check("imp_y0", orr[0], 1000);
    check("imp_y8", orr[8], 1000);
    nz = 0;
    for (int k = 0; k < N2; k++)
      if ((k != 0 && k != 8 && orr[k] != 0) || oi[k] != 0) nz++;
    check("imp_rest_nonzero", nz, 0);

    // Constant inputs, two blocks
    fill_const(100, 0);
    run_frame(1'b0, 1'b0, 2*N2 + LAT, -1);
    check("const_y0", orr[0], 200);
    check("const_y8", orr[8], 0);
    check("const_b1_y7", orr[N2+7], 200);
    check("const_b1_y15", orr[N2+15], 0);
    run_frame(1'b0, 1'b1, N2 + LAT, -1);
    check("const_scaled_y3", orr[3], 100);
    fill_const(-1, 0);
    run_frame(1'b0, 1'b1, N2 + LAT, -1);
    check("neg1_scaled_y2", orr[2], -1);
    check("neg1_scaled_y10", orr[10], 0);

    // Twiddle rounding
    fill_const(0, 0); xr[1] = 4096;
    run_frame(1'b0, 1'b0, N2 + LAT, -1);
    check("tw_y1", orr[1], 4096);
    check("tw_fft_y9_re", orr[9], 3784);
    check("tw_fft_y9_im", oi[9], -1567);
    run_frame(1'b1, 1'b0, N2 + LAT, -1);
    check("tw_ifft_y9_re", orr[9], 3784);
    check("tw_ifft_y9_im", oi[9], 1568);

    // Saturation
    fill_const(0, 0);
    xr[3] = 32767;  xi[3] = 32767;
    xr[11] = -32768; xi[11] = -32768;
    run_frame(1'b0, 1'b0, N2 + LAT, -1);
    check("sat_y3_re", orr[3], -1);
    check("sat_y3_im", oi[3], -1);
    check("sat_y11_re", orr[11], 65535);
    check("sat_y11_im", oi[11], -35467);

    // Random frames in all modes
    fill_rand(); run_frame(1'b0, 1'b0, 3*N2 + LAT, -1);
    fill_rand(); run_frame(1'b1, 1'b1, 3*N2 + LAT, -1);
    fill_rand(); run_frame(1'b1, 1'b0, 2*N2 + LAT, -1);

    // ED stall: same data with and without a 5-cycle gap
    fill_rand();
    run_frame(1'b0, 1'b1, 3*N2 + LAT, -1);
    for (int k = 0; k < MAXS; k++) begin
      sr[k] = orr[k];
      si[k] = oi[k];
    end
    run_frame(1'b0, 1'b1, 3*N2 + LAT, 21);
    for (int k = 0; k < 3*N2; k++) begin
      check($sformatf("stall_eq_re y%0d", k), orr[k], sr[k]);
      check($sformatf("stall_eq_im y%0d", k), oi[k], si[k]);
    end

    // START abort at slot 5 of a block, then a fresh frame
    fill_rand(); run_frame(1'b1, 1'b0, 2*N2 + 5, -1);
    fill_rand(); run_frame(1'b0, 1'b0, 2*N2 + LAT, -1);

    // RST abort mid-block, then recovery
    fill_rand(); run_frame(1'b0, 1'b0, N2 + 4, -1);
    reset_check("rst_mid");
    fill_rand(); run_frame(1'b0, 1'b1, N2 + LAT, -1);

    ED = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
